// File: rtl/rv32_mem_pkg.sv
// ----------------------------------------------------------------------------
// rv32_mem_pkg : shared funct3 codes and store FSM state for the MEM stage
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rv32_mem_pkg;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_FIN   = 2'd3
  } store_state_t;

  // Illegal codes yield an empty mask so no lane is ever enabled for them.
  function automatic logic [3:0] store_mask(input logic [2:0] code);
    case (code)
      F3_SB:   store_mask = 4'b0001;
      F3_SH:   store_mask = 4'b0011;
      F3_SW:   store_mask = 4'b1111;
      default: store_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic store_legal(input logic [2:0] code);
    store_legal = (code == F3_SB) || (code == F3_SH) || (code == F3_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_lane_shifter.sv
// ----------------------------------------------------------------------------
// store_lane_shifter : maps offset/code/data onto an 8-lane view of two words
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module store_lane_shifter
  import rv32_mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  code,
  input  logic [31:0] data,
  output logic [7:0]  wide_be,
  output logic [63:0] wide_data,
  output logic        split
);

  logic [3:0] w_mask;

  assign w_mask    = store_mask(code);
  assign wide_be   = {4'b0000, w_mask} << off;
  assign wide_data = {32'h0000_0000, data} << {off, 3'b000};
  assign split     = |wide_be[7:4];

endmodule

`default_nettype wire

// File: rtl/store_data_aligner.sv
// ----------------------------------------------------------------------------
// store_data_aligner : RV32I store lane alignment with a two-beat split FSM
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module store_data_aligner
  import rv32_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic [2:0]  Type_sel,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        busy,
  output logic        done,
  output logic        err
);

  store_state_t r_state;
  store_state_t w_state_nxt;

  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [2:0]  r_code;
  logic        r_err;

  logic        w_accept;
  logic [7:0]  w_wide_be;
  logic [63:0] w_wide_data;
  logic        w_split;
  logic [31:0] w_beat0_addr;

  assign w_accept     = (r_state == ST_IDLE) && req_valid;
  assign w_beat0_addr = {r_addr[31:2], 2'b00};

  store_lane_shifter u_lane_shifter (
    .off       (r_addr[1:0]),
    .code      (r_code),
    .data      (r_data),
    .wide_be   (w_wide_be),
    .wide_data (w_wide_data),
    .split     (w_split)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= 32'h0000_0000;
      r_data  <= 32'h0000_0000;
      r_code  <= 3'b000;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr <= addr;
        r_data <= data_in;
        r_code <= Type_sel;
        r_err  <= !store_legal(Type_sel);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    mem_valid   = 1'b0;
    mem_addr    = 32'h0000_0000;
    mem_wdata   = 32'h0000_0000;
    mem_be      = 4'b0000;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = store_legal(Type_sel) ? ST_BEAT0 : ST_FIN;
        end
      end
      ST_BEAT0: begin
        busy      = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = w_beat0_addr;
        mem_wdata = w_wide_data[31:0];
        mem_be    = w_wide_be[3:0];
        if (mem_ready) begin
          w_state_nxt = w_split ? ST_BEAT1 : ST_FIN;
        end
      end
      ST_BEAT1: begin
        busy      = 1'b1;
        mem_valid = 1'b1;
        // Wraps naturally at the top of the address space.
        mem_addr  = w_beat0_addr + 32'd4;
        mem_wdata = w_wide_data[63:32];
        mem_be    = w_wide_be[7:4];
        if (mem_ready) begin
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        busy        = 1'b1;
        done        = 1'b1;
        err         = r_err;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_store_data_aligner.sv
// ----------------------------------------------------------------------------
// tb_store_data_aligner : directed and randomized store checks vs. a byte model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_store_data_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [2:0]  Type_sel;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_data_aligner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .addr      (addr),
    .data_in   (data_in),
    .Type_sel  (Type_sel),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte-level reference: enumerate every stored byte address and group by word.
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c,
                       output int n,
                       output logic [31:0] a0, output logic [31:0] d0, output logic [3:0] e0,
                       output logic [31:0] a1, output logic [31:0] d1, output logic [3:0] e1);
    int nbytes;
    int off;
    logic [63:0] wide;
    nbytes = (c == 3'd0) ? 1 : (c == 3'd1) ? 2 : (c == 3'd2) ? 4 : 0;
    off    = int'(a % 4);
    a0     = a - 32'(off);
    a1     = a0 + 32'd4;
    wide   = 64'(d) * (64'd1 << (8 * off));
    d0     = wide[31:0];
    d1     = wide[63:32];
    e0     = 4'b0000;
    e1     = 4'b0000;
    for (int i = 0; i < nbytes; i++) begin
      if (off + i < 4) e0[off + i] = 1'b1;
      else             e1[off + i - 4] = 1'b1;
    end
    n = (nbytes == 0) ? 0 : (e1 != 4'b0000) ? 2 : 1;
  endtask

  // mode 0: mem_ready always high; 1: random stalls; 2: three stall cycles on first beat.
  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c,
                           input int mode);
    int          n;
    int          stalls;
    logic        rdy;
    logic [31:0] a0, d0, a1, d1;
    logic [3:0]  e0, e1;
    model(a, d, c, n, a0, d0, e0, a1, d1, e1);
    stalls    = 0;
    req_valid = 1'b1;
    addr      = a;
    data_in   = d;
    Type_sel  = c;
    mem_ready = 1'b1;
    check("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    if (n == 0) begin
      check("illegal_mem_valid", mem_valid, 0);
      check("illegal_done", done, 1);
      check("illegal_err", err, 1);
      check("illegal_busy", busy, 1);
      @(negedge clk);
      check("illegal_idle_ready", req_ready, 1);
      check("illegal_idle_done", done, 0);
      check("illegal_idle_valid", mem_valid, 0);
      return;
    end
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 20; k++) begin
        addr      = $urandom;
        data_in   = $urandom;
        Type_sel  = 3'($urandom);
        req_valid = 1'($urandom);
        check("beat_valid", mem_valid, 1);
        check("beat_addr", mem_addr, (b == 0) ? a0 : a1);
        check("beat_be", mem_be, (b == 0) ? e0 : e1);
        check("beat_wdata", mem_wdata, (b == 0) ? d0 : d1);
        check("beat_busy", busy, 1);
        check("beat_done", done, 0);
        check("beat_req_ready", req_ready, 0);
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (stalls >= 6) ? 1'b1 : 1'($urandom);
          default: rdy = (stalls >= 3);
        endcase
        mem_ready = rdy;
        if (!rdy) stalls++;
        @(negedge clk);
        if (rdy) break;
      end
    end
    req_valid = 1'b0;
    mem_ready = 1'($urandom);
    check("fin_done", done, 1);
    check("fin_err", err, 0);
    check("fin_mem_valid", mem_valid, 0);
    check("fin_mem_be", mem_be, 0);
    check("fin_busy", busy, 1);
    check("fin_req_ready", req_ready, 0);
    @(negedge clk);
    mem_ready = 1'b1;
    check("post_req_ready", req_ready, 1);
    check("post_busy", busy, 0);
    check("post_done", done, 0);
  endtask

  initial begin
    logic [2:0] code;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    addr      = 32'h0;
    data_in   = 32'h0;
    Type_sel  = 3'b000;
    mem_ready = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_store(32'h0000_1003, 32'hAABB_CC11, 3'b000, 0);
    run_store(32'h0000_2002, 32'h4433_2211, 3'b010, 0);
    run_store(32'hFFFF_FFFF, 32'h0000_BEEF, 3'b001, 0);
    run_store(32'h0000_3000, 32'hDEAD_BEEF, 3'b010, 2);
    run_store(32'h0000_4000, 32'h1234_5678, 3'b011, 0);
    run_store(32'h0000_5002, 32'hCAFE_F00D, 3'b001, 1);
    run_store(32'hFFFF_FFFD, 32'h8765_4321, 3'b010, 1);

    // Asynchronous reset while beat 1 of a split store is pending.
    req_valid = 1'b1;
    addr      = 32'h0000_6001;
    data_in   = 32'h0102_0304;
    Type_sel  = 3'b010;
    mem_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    check("pre_rst_beat1_valid", mem_valid, 1);
    check("pre_rst_beat1_addr", mem_addr, 32'h0000_6004);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_valid", mem_valid, 0);
    check("async_rst_req_ready", req_ready, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_mem_be", mem_be, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_idle", req_ready, 1);
    check("after_rst_valid", mem_valid, 0);

    for (int t = 0; t < 40; t++) begin
      code = 3'($urandom_range(0, 7));
      if (code > 3'd2 && $urandom_range(0, 2) != 0) code = 3'($urandom_range(0, 2));
      run_store($urandom, $urandom, code, int'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
